// File: rtl/led_pixel_serializer.sv
`default_nettype none
// ============================================================================
// Module   : led_pixel_serializer
// Brief    : Buffers 16-bit grayscale pixel words in a small FIFO and emits
//            each one LSB first on DAI, qualified by DEN, for the LED driver.
//            Counts words per frame and flags frames of the wrong length.
// Revision : 1.0 - initial release
// ============================================================================
module led_pixel_serializer #(
  parameter int WORDS_PER_FRAME = 256,
  parameter int GAP             = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [15:0]                        in_data,
  input  logic                               in_last,
  output logic                               DAI,
  output logic                               DEN,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               frame_err,
  output logic [$clog2(WORDS_PER_FRAME):0]   word_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WC_W  = $clog2(WORDS_PER_FRAME) + 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [WC_W-1:0]  WC_FRAME  = WC_W'(WORDS_PER_FRAME);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic             NO_GAP    = (GAP == 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // FIFO storage: {last flag, pixel word}
  logic [16:0]      mem_q [FIFO_DEPTH];
  logic [16:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  logic [1:0]       state_q, state_d;
  logic [15:0]      shreg_q, shreg_d;
  logic             last_q, last_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             den_q, den_d, dai_q, dai_d;

  // Word-end pipeline stage so frame flags line up with the cycle after the last DEN bit
  logic             end_q, end_d, end_last_q, end_last_d;
  logic             frame_done_q, frame_done_d, frame_err_q, frame_err_d;
  logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
  logic [WC_W-1:0]  wc_inc;

  logic             push, pop, word_end, fifo_nonempty, bit_last, gap_last;
  logic [16:0]      rd_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_ready      = (fifo_cnt_q != FIFO_FULL);
  assign push          = in_valid && in_ready;
  assign fifo_nonempty = (fifo_cnt_q != '0);
  assign rd_word       = mem_q[rd_ptr_q];
  assign bit_last      = (bit_cnt_q == 4'd15);
  assign gap_last      = (gap_cnt_q == GAP_LAST);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: pop whenever a word slot opens and data is waiting
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (fifo_nonempty) state_d = ST_SHIFT;
      ST_SHIFT: if (bit_last) begin
                  if (NO_GAP) state_d = fifo_nonempty ? ST_SHIFT : ST_IDLE;
                  else        state_d = ST_GAP;
                end
      ST_GAP:   if (gap_last) state_d = fifo_nonempty ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: pop strobe, word-complete strobe and next DEN/DAI values
  always_comb begin
    pop      = 1'b0;
    word_end = 1'b0;
    den_d    = 1'b0;
    dai_d    = 1'b0;
    unique case (state_q)
      ST_IDLE:  pop = fifo_nonempty;
      ST_SHIFT: begin
                  den_d    = 1'b1;
                  dai_d    = shreg_q[0];
                  word_end = bit_last;
                  pop      = bit_last && NO_GAP && fifo_nonempty;
                end
      ST_GAP:   pop = gap_last && fifo_nonempty;
      default:  ;
    endcase
  end

  // FIFO pointers, occupancy and write port
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_last, in_data};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Shift register, bit counter and inter-word gap counter
  always_comb begin
    shreg_d   = shreg_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = '0;
    if (pop) begin
      shreg_d   = rd_word[15:0];
      last_d    = rd_word[16];
      bit_cnt_d = 4'd0;
    end else if (state_q == ST_SHIFT) begin
      shreg_d   = {1'b0, shreg_q[15:1]};
      bit_cnt_d = bit_cnt_q + 4'd1;
    end
    if (state_q == ST_GAP) gap_cnt_d = gap_cnt_q + 1'b1;
  end

  // Frame accounting, applied one cycle after the word's last bit leaves DAI
  always_comb begin
    end_d        = word_end;
    end_last_d   = word_end ? last_q : end_last_q;
    wc_inc       = word_cnt_q + 1'b1;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    word_cnt_d   = word_cnt_q;
    if (end_q) begin
      if (wc_inc == WC_FRAME) begin
        frame_done_d = 1'b1;
        word_cnt_d   = '0;
      end else if (end_last_q) begin
        frame_done_d = 1'b1;
        frame_err_d  = 1'b1;
        word_cnt_d   = '0;
      end else begin
        word_cnt_d   = wc_inc;
      end
    end
  end

  // Datapath registers; async reset drops any partial word and flushes the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      shreg_q      <= '0;
      last_q       <= 1'b0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      den_q        <= 1'b0;
      dai_q        <= 1'b0;
      end_q        <= 1'b0;
      end_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      shreg_q      <= shreg_d;
      last_q       <= last_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      den_q        <= den_d;
      dai_q        <= dai_d;
      end_q        <= end_d;
      end_last_q   <= end_last_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign DEN        = den_q;
  assign DAI        = dai_q;
  assign busy       = fifo_nonempty || (state_q == ST_SHIFT) || den_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign word_cnt   = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pixel_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pixel_serializer
// Brief    : Self-checking bench for led_pixel_serializer. Three instances
//            (GAP=1, GAP=0, GAP=3) share clock and reset; a stream-level
//            scoreboard checks DAI/DEN/frame flags every cycle and directed
//            sequences pin exact timing and literal bit patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pixel_serializer;

  localparam int NI  = 3;
  localparam int WPF = 256;
  localparam int WCW = $clog2(WPF) + 1;
  localparam int QSZ = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           vld  [NI];
  logic           rdy  [NI];
  logic [15:0]    dat  [NI];
  logic           lst  [NI];
  logic           dai  [NI];
  logic           den  [NI];
  logic           bsy  [NI];
  logic           fdn  [NI];
  logic           fer  [NI];
  logic [WCW-1:0] wcnt [NI];

  // instance 0: GAP=1, instance 1: GAP=0, instance 2: GAP=3
  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int GP = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
    led_pixel_serializer #(.WORDS_PER_FRAME(WPF), .GAP(GP), .FIFO_DEPTH(4)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (vld[gi]),
      .in_ready   (rdy[gi]),
      .in_data    (dat[gi]),
      .in_last    (lst[gi]),
      .DAI        (dai[gi]),
      .DEN        (den[gi]),
      .busy       (bsy[gi]),
      .frame_done (fdn[gi]),
      .frame_err  (fer[gi]),
      .word_cnt   (wcnt[gi])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stream-level scoreboard ----------------
  logic [16:0] mq   [NI][QSZ];
  int          mwr  [NI];
  int          mrd  [NI];
  int          mbit [NI];
  int          mcnt [NI];
  logic [16:0] mcur [NI];
  bit          pdone[NI];
  bit          perr [NI];

  // Every accepted word must reappear as one unbroken 16-bit LSB-first burst, in order
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        mrd[k]   = mwr[k];
        mbit[k]  = 0;
        mcnt[k]  = 0;
        pdone[k] = 1'b0;
        perr[k]  = 1'b0;
      end else begin
        check($sformatf("frame_done%0d", k), fdn[k], pdone[k]);
        check($sformatf("frame_err%0d", k), fer[k], perr[k]);
        check($sformatf("word_cnt%0d", k), wcnt[k], mcnt[k]);
        pdone[k] = 1'b0;
        perr[k]  = 1'b0;
        if (den[k]) begin
          if (mbit[k] == 0) begin
            check($sformatf("word_available%0d", k), (mrd[k] != mwr[k]), 1);
            mcur[k] = mq[k][mrd[k] % QSZ];
            mrd[k]++;
          end
          check($sformatf("dai%0d_bit%0d", k, mbit[k]), dai[k], mcur[k][mbit[k]]);
          mbit[k]++;
          if (mbit[k] == 16) begin
            mbit[k] = 0;
            if (mcnt[k] + 1 == WPF) begin
              pdone[k] = 1'b1;
              mcnt[k]  = 0;
            end else if (mcur[k][16]) begin
              pdone[k] = 1'b1;
              perr[k]  = 1'b1;
              mcnt[k]  = 0;
            end else begin
              mcnt[k]  = mcnt[k] + 1;
            end
          end
        end else begin
          check($sformatf("dai_idle%0d", k), dai[k], 0);
          check($sformatf("burst_whole%0d", k), mbit[k], 0);
          mbit[k] = 0;
        end
        if (vld[k] && rdy[k]) begin
          mq[k][mwr[k] % QSZ] = {lst[k], dat[k]};
          mwr[k]++;
        end
      end
    end
  end

  // ---------------- event counters for directed checks ----------------
  int fd_n = 0, fe_n = 0, both_n = 0;
  int hi_len [16];
  int lo_len [16];
  int n_hi = 0, n_lo = 0, cur_hi = 0, cur_lo = 0;
  bit seen_hi = 1'b0;

  // Frame pulses on instance 0 and DEN run lengths on instance 2
  always @(negedge clk) begin
    if (!rst) begin
      if (fdn[0]) fd_n++;
      if (fer[0]) fe_n++;
      if (fdn[0] && fer[0]) both_n++;
      if (den[2]) begin
        if (seen_hi && cur_lo > 0 && n_lo < 16) begin
          lo_len[n_lo] = cur_lo;
          n_lo++;
        end
        cur_lo  = 0;
        cur_hi++;
        seen_hi = 1'b1;
      end else begin
        if (cur_hi > 0 && n_hi < 16) begin
          hi_len[n_hi] = cur_hi;
          n_hi++;
        end
        cur_hi = 0;
        if (seen_hi) cur_lo++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [15:0] d, input logic l, output int stalls);
    bit acc;
    acc    = 1'b0;
    stalls = 0;
    vld[k] = 1'b1;
    dat[k] = d;
    lst[k] = l;
    while (!acc) begin
      acc = rdy[k];
      tick();
      if (!acc) begin
        stalls++;
        if (stalls > 2000) begin
          check($sformatf("push_timeout%0d", k), stalls, 0);
          acc = 1'b1;
        end
      end
    end
    vld[k] = 1'b0;
    lst[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (bsy[k] || den[k]) begin
      tick();
      n++;
      if (n > 3000) begin
        check($sformatf("idle_timeout%0d", k), n, 0);
        break;
      end
    end
    repeat (3) tick();
  endtask

  logic [15:0] bits16;
  logic [31:0] bits32;
  logic [15:0] w3 [6];
  int          st, dcnt, first_stall, fd0, fe0, both0;

  initial begin
    w3[0] = 16'h1111; w3[1] = 16'h2222; w3[2] = 16'h3333;
    w3[3] = 16'h4444; w3[4] = 16'h5555; w3[5] = 16'h6666;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      vld[k] = 1'b0;
      dat[k] = 16'h0000;
      lst[k] = 1'b0;
    end
    repeat (3) tick();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_den%0d", k), den[k], 0);
      check($sformatf("rst_dai%0d", k), dai[k], 0);
      check($sformatf("rst_ready%0d", k), rdy[k], 1);
      check($sformatf("rst_busy%0d", k), bsy[k], 0);
      check($sformatf("rst_fdone%0d", k), fdn[k], 0);
      check($sformatf("rst_ferr%0d", k), fer[k], 0);
      check($sformatf("rst_wcnt%0d", k), wcnt[k], 0);
    end
    rst = 1'b0;
    tick();

    // single word 0xA5C3, GAP=1: DEN high from t+2 for 16 cycles
    push(0, 16'hA5C3, 1'b0, st);
    tick();
    check("t1_den_at_t1", den[0], 0);
    tick();
    dcnt = 0;
    for (int i = 0; i < 16; i++) begin
      bits16[i] = dai[0];
      dcnt += int'(den[0]);
      tick();
    end
    check("t1_bits", bits16, 16'hA5C3);
    check("t1_den_cycles", dcnt, 16);
    check("t1_den_after", den[0], 0);
    check("t1_word_cnt", wcnt[0], 1);
    tick();
    check("t1_busy_fell", bsy[0], 0);

    // GAP=0: 0x0001 then 0x8000 give 32 contiguous DEN cycles
    vld[1] = 1'b1;
    dat[1] = 16'h0001;
    tick();
    dat[1] = 16'h8000;
    tick();
    vld[1] = 1'b0;
    check("t2_den_pre", den[1], 0);
    tick();
    dcnt = 0;
    for (int i = 0; i < 32; i++) begin
      bits32[i] = dai[1];
      dcnt += int'(den[1]);
      tick();
    end
    check("t2_bits", bits32, 32'h8000_0001);
    check("t2_den_cycles", dcnt, 32);
    check("t2_den_after", den[1], 0);
    check("t2_word_cnt", wcnt[1], 2);

    // GAP=3 with valid held: back-pressure after 5 accepted, gaps of exactly 3
    first_stall = -1;
    for (int i = 0; i < 6; i++) begin
      push(2, w3[i], 1'b0, st);
      if (st > 0 && first_stall < 0) first_stall = i;
    end
    check("t3_accepted_before_stall", first_stall, 5);
    wait_idle(2);
    check("t3_bursts", n_hi, 6);
    for (int i = 0; i < 6; i++) check($sformatf("t3_burst_len%0d", i), hi_len[i], 16);
    check("t3_gaps", n_lo, 5);
    for (int i = 0; i < 5; i++) check($sformatf("t3_gap_len%0d", i), lo_len[i], 3);

    // full 256-word frame closed by in_last on the final word
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    fd0 = fd_n; fe0 = fe_n;
    for (int i = 0; i < 256; i++) push(0, 16'((i * 257) ^ 16'h5A5A), (i == 255), st);
    wait_idle(0);
    check("t4_done_pulses", fd_n - fd0, 1);
    check("t4_err_pulses", fe_n - fe0, 0);
    check("t4_word_cnt", wcnt[0], 0);

    // short frame of 10 words: done and err together, count restarts
    fd0 = fd_n; fe0 = fe_n; both0 = both_n;
    for (int i = 0; i < 10; i++) push(0, 16'(16'hC000 + i), (i == 9), st);
    wait_idle(0);
    check("t5_done_pulses", fd_n - fd0, 1);
    check("t5_err_pulses", fe_n - fe0, 1);
    check("t5_coincident", both_n - both0, 1);
    check("t5_word_cnt", wcnt[0], 0);
    push(0, 16'h0F0F, 1'b0, st);
    wait_idle(0);
    check("t5_next_word_cnt", wcnt[0], 1);

    // reset at bit 7 of 0xFFFF with a second word still queued
    push(0, 16'hFFFF, 1'b0, st);
    push(0, 16'hFFFF, 1'b0, st);
    repeat (8) tick();
    check("t6_den_bit7", den[0], 1);
    check("t6_dai_bit7", dai[0], 1);
    rst = 1'b1;
    #1;
    check("t6_den_async", den[0], 0);
    check("t6_dai_async", dai[0], 0);
    check("t6_ready", rdy[0], 1);
    check("t6_busy", bsy[0], 0);
    check("t6_wcnt", wcnt[0], 0);
    tick();
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      dcnt += int'(den[0]);
      tick();
    end
    check("t6_fifo_flushed", dcnt, 0);
    push(0, 16'h1234, 1'b0, st);
    tick();
    check("t6_den_at_t1", den[0], 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      bits16[i] = dai[0];
      tick();
    end
    check("t6_fresh_bits", bits16, 16'h1234);
    wait_idle(0);
    check("t6_fresh_wcnt", wcnt[0], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
